// File: rtl/counter_share_pkg.sv
// Shared types and sizing for the counter-sharing arbiter.
package counter_share_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 3;
  localparam int unsigned PTR_W    = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick
  import counter_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned PW   = PTR_W
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  logic        w_found;
  int unsigned w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = |i_req;
    w_found  = 1'b0;
    w_pos    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_pos = (32'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[w_pos]) begin
        w_found         = 1'b1;
        o_onehot[w_pos] = 1'b1;
        o_idx           = PW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/counter_share_arb.sv
// Round-robin arbiter sharing one up-counter engine between NREQ requesters.
// Each grant counts 0..len of the owner, pulses done, then re-arbitrates.
module counter_share_arb
  import counter_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      cnt,
  output logic              busy
);

  localparam int unsigned PW = $clog2(NREQ);

  state_t          r_state, w_state_n;
  logic [NREQ-1:0] r_gnt,   w_gnt_n;
  logic [NREQ-1:0] r_done,  w_done_n;
  logic [W-1:0]    r_cnt,   w_cnt_n;
  logic [W-1:0]    r_len,   w_len_n;
  logic [PW-1:0]   r_ptr,   w_ptr_n;
  logic [PW-1:0]   r_idx,   w_idx_n;
  logic            r_busy,  w_busy_n;

  logic [NREQ-1:0] w_pick_oh;
  logic [PW-1:0]   w_pick_idx;
  logic            w_pick_valid;
  logic [PW-1:0]   w_ptr_inc;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_onehot(w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Pointer moves past the owner so other pending requesters win next.
  assign w_ptr_inc = (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + PW'(1);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_done  <= w_done_n;
      r_cnt   <= w_cnt_n;
      r_len   <= w_len_n;
      r_ptr   <= w_ptr_n;
      r_idx   <= w_idx_n;
      r_busy  <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_done_n  = '0;
    w_cnt_n   = r_cnt;
    w_len_n   = r_len;
    w_ptr_n   = r_ptr;
    w_idx_n   = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        w_gnt_n = '0;
        w_cnt_n = '0;
        if (w_pick_valid) begin
          w_state_n = ST_RUN;
          w_gnt_n   = w_pick_oh;
          w_idx_n   = w_pick_idx;
          w_len_n   = len[W*32'(w_pick_idx) +: W];
        end
      end
      ST_RUN: begin
        // Abort takes priority over the terminal test.
        if (!req[r_idx]) begin
          w_state_n = ST_IDLE;
          w_gnt_n   = '0;
          w_cnt_n   = '0;
          w_ptr_n   = w_ptr_inc;
        end else if (r_cnt == r_len) begin
          w_state_n = ST_DONE;
          w_gnt_n   = '0;
          w_done_n  = r_gnt;
          w_ptr_n   = w_ptr_inc;
        end else begin
          w_cnt_n = r_cnt + W'(1);
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
        w_gnt_n   = '0;
        w_cnt_n   = '0;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_gnt_n   = '0;
        w_cnt_n   = '0;
      end
    endcase
    w_busy_n = (w_state_n != ST_IDLE);
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign cnt  = r_cnt;
  assign busy = r_busy;

endmodule

// File: doc/counter_share_arb.md
Name: counter_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one W-bit up-counter engine between NREQ requesters.
- Each requester asks for a count run of a given terminal value. The block grants one requester at a time, counts the engine from 0 up to that value, pulses done to the owner, then re-arbitrates.
- Sits between client blocks needing timed intervals and the shared counter datapath. The counter is internal, so no external counter instance is needed.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 3, counter width; terminal value range 0..2^W-1.

Ports:
- clk  input  1  rising-edge clock.
- res  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; must be held until done or aborts the run.
- len  input  NREQ*W  per-requester terminal count; slice i = len[i*W +: W]; sampled only at grant.
- gnt  output  NREQ  one-hot grant; registered; high for the whole RUN of the owner.
- done  output  NREQ  one-cycle completion pulse to the owner; registered.
- cnt  output  W  current engine count; registered.
- busy  output  1  high in RUN and DONE states.

Behaviour:
- Reset (async, res=1): state=IDLE, gnt=0, done=0, cnt=0, busy=0, rr pointer=0, latched len=0. All outputs are registered and take these values immediately on res assertion.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select winner idx = first set bit of req searching from pointer upward, wrapping modulo NREQ.
  - Next cycle: gnt=onehot(idx), len_q=len slice idx, cnt=0, busy=1, state=RUN.
- RUN:
  - Each cycle: if cnt==len_q, go to DONE; else cnt=cnt+1.
  - Run length is exactly len_q+1 cycles with gnt high. len_q=0 gives one cycle.
  - cnt never wraps; maximum is 2^W-1 when len_q=all ones.
- Abort: req[idx]==0 in any RUN cycle (checked before the terminal test):
  - Next cycle: state=IDLE, gnt=0, cnt=0, busy=0, no done pulse, pointer=idx+1 mod NREQ.
- DONE (exactly one cycle):
  - done[idx]=1, gnt=0, cnt holds len_q, busy=1, pointer=idx+1 mod NREQ.
  - Next cycle: state=IDLE, done=0, cnt=0, busy=0.
- Requester protocol:
  - Drop req in the cycle after seeing done; otherwise it is re-arbitrated.
  - Because the pointer has advanced, other pending requesters win first, which guarantees fairness.
- len is don't-care except in the IDLE cycle where its requester wins. Changing len during RUN has no effect.
- New requests arriving during RUN/DONE wait; they have no effect until the next IDLE.
- Throughput: one grant per len_q+3 cycles (IDLE, RUN × (len_q+1), DONE).
- Latency: req rise in IDLE at edge N gives gnt high after edge N+1.
- At most one bit of gnt and of done is high at any time; gnt and done are never high in the same cycle.
- Reset mid-run: outputs clear asynchronously, no done pulse is issued, and the pointer returns to 0.

Decomposition:
- Shared package counter_share_pkg holds:
  - state enum (IDLE, RUN, DONE) with a 2-bit encoding;
  - localparam PTR_W = $clog2(NREQ).
- One sub-module, rr_pick: combinational, inputs req and pointer, outputs a one-hot winner plus its index and an any-valid flag.
- FSM, counter, len latch and pointer stay in counter_share_arb.

Test Plan:
- Single request: req=0001, len0=5 -> gnt=0001 for 6 cycles with cnt 0,1,2,3,4,5; done=0001 for one cycle with cnt=5; then cnt=0 and busy=0.
- Round-robin: req=0101 held, len0=2, len2=1 -> grants 0001 then 0100 then 0001; each done pulse lands on the matching bit; no requester is granted twice in a row while another is pending.
- Terminal edges: len=0 -> 1-cycle RUN and done with cnt=0. len=7 (W=3) -> 8-cycle RUN reaching cnt=7, no wrap to 0 before DONE.
- Abort: req=0010, len1=6, drop req1 when cnt=3 -> next cycle gnt=0, cnt=0, busy=0, no done, pointer=2.
- Reset mid-run: assert res while cnt=4, between clock edges -> gnt, done, cnt and busy go 0 immediately. After release with req=1000 held, the first grant is 1000 (search from pointer 0).
- Late request and len stability: raise req3 during RUN of req0 and change len0 mid-run -> req0 run length is unchanged; req3 is granted in the IDLE following req0's DONE.
